// File: rtl/vga_timing_ctrl_pkg.sv
// Shared types, default 640x480@60 raster timing and width helpers for the VGA timing controller.
package vga_timing_ctrl_pkg;

  typedef enum logic [1:0] {
    PH_VIS  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  localparam int unsigned DFLT_H_VIS  = 640;
  localparam int unsigned DFLT_H_FP   = 16;
  localparam int unsigned DFLT_H_SYNC = 96;
  localparam int unsigned DFLT_H_BP   = 48;
  localparam int unsigned DFLT_V_VIS  = 480;
  localparam int unsigned DFLT_V_FP   = 10;
  localparam int unsigned DFLT_V_SYNC = 2;
  localparam int unsigned DFLT_V_BP   = 33;
  localparam int unsigned DFLT_DIV    = 2;
  localparam int unsigned DFLT_CW     = 10;

  // Full period of one axis (visible + porches + sync).
  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_mod_counter_en.sv
// Modulo-N counter with synchronous clear, count enable and a combinational carry on the wrap.
module mod_counter_en #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] nxt_c,
  output logic         wrap_c
);

  logic [W-1:0] cnt;

  assign wrap_c = en && (cnt == W'(N - 1));

  always_comb begin
    nxt_c = cnt;
    if (clr || wrap_c) begin
      nxt_c = '0;
    end else if (en) begin
      nxt_c = cnt + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= nxt_c;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel-rate prescaler, h/v modulo counters, phase FSMs and registered sync/video outputs.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned H_VIS  = DFLT_H_VIS,
  parameter int unsigned H_FP   = DFLT_H_FP,
  parameter int unsigned H_SYNC = DFLT_H_SYNC,
  parameter int unsigned H_BP   = DFLT_H_BP,
  parameter int unsigned V_VIS  = DFLT_V_VIS,
  parameter int unsigned V_FP   = DFLT_V_FP,
  parameter int unsigned V_SYNC = DFLT_V_SYNC,
  parameter int unsigned V_BP   = DFLT_V_BP,
  parameter int unsigned DIV    = DFLT_DIV,
  parameter int unsigned CW     = DFLT_CW
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_pix_tick,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_video_on,
  output logic          o_frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_VIS, V_FP, V_SYNC, V_BP);
  localparam int unsigned PW      = cnt_width(DIV);

  logic          tick_c;
  logic          h_wrap_c;
  logic          v_wrap_c;
  logic          v_en_c;
  logic [PW-1:0] p_nxt_c;
  logic [CW-1:0] h_nxt_c;
  logic [CW-1:0] v_nxt_c;
  logic          unused_presc;

  phase_e h_state, h_state_n;
  phase_e v_state, v_state_n;

  // Map a count onto its phase; boundaries are the cumulative phase lengths.
  function automatic phase_e decode(input logic [CW-1:0] c, input int unsigned vis,
                                    input int unsigned fp, input int unsigned sync);
    phase_e ph;
    if (c < CW'(vis)) begin
      ph = PH_VIS;
    end else if (c < CW'(vis + fp)) begin
      ph = PH_FP;
    end else if (c < CW'(vis + fp + sync)) begin
      ph = PH_SYNC;
    end else begin
      ph = PH_BP;
    end
    return ph;
  endfunction

  mod_counter_en #(.N(DIV), .W(PW)) u_presc (
    .clk    (clk),
    .rst    (i_rst),
    .clr    (1'b0),
    .en     (i_en),
    .nxt_c  (p_nxt_c),
    .wrap_c (tick_c)
  );

  mod_counter_en #(.N(H_TOTAL), .W(CW)) u_hcnt (
    .clk    (clk),
    .rst    (i_rst),
    .clr    (1'b0),
    .en     (tick_c),
    .nxt_c  (h_nxt_c),
    .wrap_c (h_wrap_c)
  );

  assign v_en_c = tick_c & h_wrap_c;

  mod_counter_en #(.N(V_TOTAL), .W(CW)) u_vcnt (
    .clk    (clk),
    .rst    (i_rst),
    .clr    (1'b0),
    .en     (v_en_c),
    .nxt_c  (v_nxt_c),
    .wrap_c (v_wrap_c)
  );

  assign unused_presc = ^p_nxt_c;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      h_state <= PH_VIS;
      v_state <= PH_VIS;
    end else begin
      h_state <= h_state_n;
      v_state <= v_state_n;
    end
  end

  // Phases only move when their counter moves, so they track the next-state counts.
  always_comb begin
    h_state_n = h_state;
    v_state_n = v_state;
    if (tick_c) begin
      h_state_n = decode(h_nxt_c, H_VIS, H_FP, H_SYNC);
    end
    if (v_en_c) begin
      v_state_n = decode(v_nxt_c, V_VIS, V_FP, V_SYNC);
    end
  end

  // Output registers; frozen (pulses low) while the run enable is off.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_pix_tick    <= 1'b0;
      o_frame_start <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_video_on    <= 1'b0;
    end else begin
      o_pix_tick    <= tick_c;
      o_frame_start <= v_wrap_c;
      if (i_en) begin
        o_x        <= h_nxt_c;
        o_y        <= v_nxt_c;
        o_hsync    <= (h_state_n != PH_SYNC);
        o_vsync    <= (v_state_n != PH_SYNC);
        o_video_on <= (h_state_n == PH_VIS) && (v_state_n == PH_VIS);
      end
    end
  end

endmodule
